// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default RX FIFO depth and the byte type
// used by UART_rx, UART_tx and uart_rx_fifo.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer signal bundle for uart_rx_fifo. The overrun pair exists
// only when UART_RX_FIFO_OVERRUN_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic              overrun;
    logic              overrun_clr;
`endif

    // master: UART_rx + consumer side; slave: the FIFO itself
    modport master (
        output rx_done, rx_data, rd_en,
`ifdef UART_RX_FIFO_OVERRUN_EN
        output overrun_clr,
        input  overrun,
`endif
        input  rd_data, rd_valid, empty, full, count
    );

    modport slave (
        input  rx_done, rx_data, rd_en,
`ifdef UART_RX_FIFO_OVERRUN_EN
        input  overrun_clr,
        output overrun,
`endif
        output rd_data, rd_valid, empty, full, count
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read that
// holds its value when no read is requested.
module uart_rx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // storage is deliberately left out of reset
    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // a same-address write in this cycle is not visible: the read sees the old entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer behind UART_rx: pointer, occupancy and flag control.
// Optional sticky overrun flag enabled by UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic          clock,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          rd_valid_q;
    logic          wr_acc, rd_acc;

    // a read frees a slot in the same cycle, so full + read still accepts the write
    assign wr_acc = bus.rx_done && (!full_q || bus.rd_en);
    assign rd_acc = bus.rd_en && !empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (rd_acc) rptr_d = rptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_valid_q <= rd_acc;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (bus.rx_data),
        .re_i    (rd_acc),
        .raddr_i (rptr_q),
        .rdata_o (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q, overrun_d;

    // set has priority over a coincident clear
    always_comb begin
        overrun_d = overrun_q;
        if (bus.overrun_clr)                         overrun_d = 1'b0;
        if (bus.rx_done && full_q && !bus.rd_en)     overrun_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic clock;
    logic reset;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // reference model: byte queue plus last-read state
    uart_byte_t m_q[$];
    uart_byte_t m_data;
    bit         m_valid;
`ifdef UART_RX_FIFO_OVERRUN_EN
    bit         m_ovr;
    bit         clr_cmd;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count",    32'(bus.count),    32'(m_q.size()));
        check("empty",    32'(bus.empty),    32'(m_q.size() == 0));
        check("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("rd_data",  32'(bus.rd_data),  32'(m_data));
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("overrun",  32'(bus.overrun),  32'(m_ovr));
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        m_ovr   = 1'b0;
`endif
    endtask

    // one clock of traffic; model applies the rules using occupancy before the edge
    task automatic step(input bit wr, input uart_byte_t d, input bit rd);
        int  n;
        bit  rd_ok, wr_ok;
        bus.rx_done = wr;
        bus.rx_data = d;
        bus.rd_en   = rd;
`ifdef UART_RX_FIFO_OVERRUN_EN
        bus.overrun_clr = clr_cmd;
`endif
        @(posedge clock);
        n     = m_q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd);
        m_valid = rd_ok;
        if (rd_ok) m_data = m_q.pop_front();
        if (wr_ok) m_q.push_back(d);
`ifdef UART_RX_FIFO_OVERRUN_EN
        if (wr && n == DEPTH && !rd) m_ovr = 1'b1;
        else if (clr_cmd)            m_ovr = 1'b0;
`endif
        #1;
        check_all();
    endtask

    initial begin
        int pw, pr;
        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.rd_en   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        clr_cmd = 1'b0;
        bus.overrun_clr = 1'b0;
`endif
        model_reset();

        // reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rx_done = 1'($urandom);
            bus.rx_data = 8'($urandom);
            bus.rd_en   = 1'($urandom);
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b1;

        // single byte
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("single_data", 32'(bus.rd_data), 32'h5A);
        step(1'b0, 8'h00, 1'b0);

        // fill, partial drain, wrap, full drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 16; i < 20; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 4; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_order", 32'(bus.rd_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0);

        // overflow while full: byte dropped, overrun raised
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b0, 8'h00, 1'b0);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("ovr_set", 32'(bus.overrun), 32'd1);
        // set and clear together: set wins
        clr_cmd = 1'b1;
        step(1'b1, 8'hEF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        clr_cmd = 1'b0;
`endif

        // full plus write and read: oldest out, new in
        step(1'b1, 8'h33, 1'b1);
        check("full_both_data", 32'(bus.rd_data), 32'h80);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // empty plus write and read: write only, no bypass
        step(1'b1, 8'h44, 1'b1);
        check("empty_both_valid", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // random traffic with alternating write/read bias
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 30;
            pr = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 200; i++) begin
`ifdef UART_RX_FIFO_OVERRUN_EN
                clr_cmd = ($urandom_range(0, 99) < 5);
`endif
                step(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr));
            end
            // asynchronous reset mid-operation once
            if (ph == 4) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_all();
                @(posedge clock);
                #1 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of `UART_rx`. It captures each byte presented on `d_out` when `rx_done` pulses, stores up to `DEPTH` bytes in a circular buffer, and hands them to the consumer (debug/command unit) through a registered read port. This decouples UART byte arrival from consumer latency, so back-to-back frames at the `UART_baud_rate_generator` rate are not lost while the consumer is busy.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `DATA_W`, 8: byte width; matches `UART_rx` `d_out`.

Ports:
- `clock`, input, 1: single system clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `rx_done`, input, 1: one-clock write strobe from `UART_rx`.
- `rx_data`, input, DATA_W: byte from `UART_rx` `d_out`; sampled when `rx_done`=1.
- `rd_en`, input, 1: consumer pop request.
- `rd_data`, output, DATA_W: popped byte; registered.
- `rd_valid`, output, 1: one-clock pulse marking `rd_data` as new.
- `empty`, output, 1: no stored bytes.
- `full`, output, 1: `DEPTH` stored bytes.
- `count`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overrun`, output, 1: sticky lost-byte flag. Present only with `UART_RX_FIFO_OVERRUN_EN`.
- `overrun_clr`, input, 1: clears `overrun`. Present only with `UART_RX_FIFO_OVERRUN_EN`.

## Operation
- Storage: `DEPTH`×`DATA_W` array with a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping naturally modulo `DEPTH`. `count` is held in a separate register.
- Write accepted: `rx_done && (!full || rd_en)`. Writes `rx_data` at the write pointer, then increments the write pointer.
- Read accepted: `rd_en && !empty`. Loads `rd_data` from the read pointer, asserts `rd_valid` on the next cycle, and increments the read pointer.
- `rd_en` while empty is ignored: `rd_data` holds its value and `rd_valid` stays 0.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous write and read:
  - When full: both are accepted; `count` stays at `DEPTH`.
  - When empty: only the write is accepted. There is no bypass, so the read is ignored.
- `rx_done` while full and no read: the byte is dropped and the array is unchanged.
- Flags `empty`/`full` are registered and derived from the next-state `count`, so they are exact in the same cycle that `count` changes.
- No state machine: the behaviour is pointer/counter datapath only.
- Reset, asynchronous and also mid-operation: pointers=0, `count`=0, `empty`=1, `full`=0, `rd_data`=0, `rd_valid`=0, `overrun`=0. Array contents are not reset.

## Timing
- Write-to-visible latency: a byte written at edge N raises `count`/clears `empty` at N. It can be popped by `rd_en` at edge N+1, with data at N+1 and `rd_valid` high during cycle N+1..N+2.
- Read latency: one clock, from `rd_en` sampled to `rd_data`/`rd_valid` valid.
- Sustained throughput: one write and one read per clock.
- Strobe width: `rx_done` is a single-cycle pulse. A multi-cycle high level writes once per cycle, and the block does not filter it.
- Release of `reset` is not synchronised internally. The system releases it synchronously to `clock`.

## Configuration
- `UART_RX_FIFO_OVERRUN_EN` defined:
  - Adds the `overrun` and `overrun_clr` ports.
  - `overrun` sets on the edge following a dropped write (`rx_done && full && !rd_en`).
  - `overrun` holds until `overrun_clr`=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- Not defined:
  - Ports and flag logic are absent.
  - Dropped writes are silently discarded.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W`=8, the default `UART_RX_FIFO_DEPTH`=16, and a `uart_byte_t` typedef shared with `UART_rx`/`UART_tx`.
- One sub-module, `uart_rx_fifo_mem`: simple dual-port register array (write port: address, data, enable; read port: address, registered data). All pointer, count and flag control stays in `uart_rx_fifo`.

## Test plan
- Reset: hold `reset`=0 with random inputs → `empty`=1, `full`=0, `count`=0, `rd_valid`=0, `rd_data`=0x00.
- Single byte: pulse `rx_done` with 0x5A, then `rd_en` → `count` 1→0, `rd_data`=0x5A with a one-cycle `rd_valid`, `empty`=1 afterwards.
- Fill/wrap (DEPTH=16): write 0x00..0x0F → `full`=1, `count`=16. Pop 4 bytes, write 0x10..0x13, then drain all → output order 0x00..0x13 with no gaps.
- Overflow: while full, pulse `rx_done` with 0xEE and no `rd_en` → `count` stays 16, 0xEE is never read, and `overrun`=1 (macro on) until `overrun_clr`.
- Simultaneous events:
  - Full plus `rx_done`+`rd_en` → oldest byte out, new byte stored, `count`=16.
  - Empty plus both → `count`=1, `rd_valid`=0.
- Integration: drive `UART_rx` with serial frames 0x75 then 0xAA back-to-back, with `rd_en` held 0 → after both frames `count`=2. Two pops return 0x75 then 0xAA.
